// File: rtl/note_sequencer_if.sv
// rtl/note_sequencer_if.sv - strobe, playback and draw-handshake signals of the note sequencer
interface note_sequencer_if #(
  parameter int AW = 4
);
  logic [3:0]    note_data;
  logic [1:0]    octave_data;
  logic          ld_note;
  logic          play;
  logic          stop;
  logic          clear;
  logic          loop_mode;
  logic          draw_ack;
  logic [3:0]    cur_note;
  logic [1:0]    cur_octave;
  logic          note_valid;
  logic          playing;
  logic          done;
  logic [AW:0]   count;
  logic          full;
  logic          draw_req;
  logic [AW-1:0] draw_slot;
  logic [5:0]    draw_entry;

  modport master (
    output note_data, octave_data, ld_note, play, stop, clear, loop_mode, draw_ack,
    input  cur_note, cur_octave, note_valid, playing, done, count, full,
           draw_req, draw_slot, draw_entry
  );

  modport slave (
    input  note_data, octave_data, ld_note, play, stop, clear, loop_mode, draw_ack,
    output cur_note, cur_octave, note_valid, playing, done, count, full,
           draw_req, draw_slot, draw_entry
  );
endinterface

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - records {octave,note} slots and plays them back one per TICKS cycles
module note_sequencer #(
  parameter int DEPTH = 16,
  parameter int TICKS = 12500000,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  note_sequencer_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PLAY = 1'b1;
  localparam int TW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [0:0]    state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    cur_q, cur_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic          full_q, full_d;
  logic          draw_req_q, draw_req_d;
  logic [AW-1:0] draw_slot_q, draw_slot_d;
  logic [5:0]    draw_entry_q, draw_entry_d;
  logic [5:0]    mem_q [DEPTH];
  logic [5:0]    mem_d [DEPTH];
  logic          last_slot;

  assign last_slot = ({1'b0, rd_ptr_q} == (count_q - (AW+1)'(1)));

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    tick_d       = tick_q;
    cur_d        = cur_q;
    valid_d      = valid_q;
    done_d       = 1'b0;
    draw_req_d   = draw_req_q;
    draw_slot_d  = draw_slot_q;
    draw_entry_d = draw_entry_q;
    mem_d        = mem_q;

    if (draw_req_q && bus.draw_ack) begin
      draw_req_d = 1'b0;
    end

    // Strobe priority clear > stop > play > ld_note is encoded by branch order.
    if (bus.clear) begin
      state_d    = IDLE;
      count_d    = '0;
      rd_ptr_d   = '0;
      tick_d     = '0;
      cur_d      = '0;
      valid_d    = 1'b0;
      draw_req_d = 1'b0;
    end else if (state_q == PLAY) begin
      if (bus.stop) begin
        state_d  = IDLE;
        rd_ptr_d = '0;
        tick_d   = '0;
        cur_d    = '0;
        valid_d  = 1'b0;
      end else if (tick_q == TW'(TICKS - 1)) begin
        tick_d = '0;
        if (!last_slot) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          cur_d    = mem_q[rd_ptr_d];
        end else if (bus.loop_mode) begin
          rd_ptr_d = '0;
          cur_d    = mem_q[0];
          done_d   = 1'b1;
        end else begin
          state_d  = IDLE;
          rd_ptr_d = '0;
          cur_d    = '0;
          valid_d  = 1'b0;
          done_d   = 1'b1;
        end
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end else if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.play) begin
      if (count_q != '0) begin
        state_d  = PLAY;
        rd_ptr_d = '0;
        tick_d   = '0;
        cur_d    = mem_q[0];
        valid_d  = 1'b1;
      end
    end else if (bus.ld_note && !full_q && !draw_req_q) begin
      mem_d[count_q[AW-1:0]] = {bus.octave_data, bus.note_data};
      count_d      = count_q + (AW+1)'(1);
      draw_req_d   = 1'b1;
      draw_slot_d  = count_q[AW-1:0];
      draw_entry_d = {bus.octave_data, bus.note_data};
    end

    full_d = (count_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      tick_q       <= '0;
      cur_q        <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      full_q       <= 1'b0;
      draw_req_q   <= 1'b0;
      draw_slot_q  <= '0;
      draw_entry_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      tick_q       <= tick_d;
      cur_q        <= cur_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      full_q       <= full_d;
      draw_req_q   <= draw_req_d;
      draw_slot_q  <= draw_slot_d;
      draw_entry_q <= draw_entry_d;
    end
  end

  // Slot contents are only meaningful below count, so the array needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.cur_note   = cur_q[3:0];
  assign bus.cur_octave = cur_q[5:4];
  assign bus.note_valid = valid_q;
  assign bus.playing    = (state_q == PLAY);
  assign bus.done       = done_q;
  assign bus.count      = count_q;
  assign bus.full       = full_q;
  assign bus.draw_req   = draw_req_q;
  assign bus.draw_slot  = draw_slot_q;
  assign bus.draw_entry = draw_entry_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - scoreboard bench for note_sequencer at DEPTH=4, TICKS=3
module tb_note_sequencer;
  localparam int DEPTH = 4;
  localparam int TICKS = 3;
  localparam int AW    = 2;

  typedef struct {
    logic       v;
    logic [5:0] e;
    logic       d;
  } play_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  logic [5:0] m_mem [DEPTH];
  int         m_count;
  logic       m_pend;
  play_t      pq[$];
  int         dq[$];

  note_sequencer_if #(.AW(AW)) bus();

  note_sequencer #(.DEPTH(DEPTH), .TICKS(TICKS), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_playing", 32'(bus.playing), 0);
    chk("rst_valid", 32'(bus.note_valid), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_cur", 32'({bus.cur_octave, bus.cur_note}), 0);
    chk("rst_draw_req", 32'(bus.draw_req), 0);
    chk("rst_draw_slot", 32'(bus.draw_slot), 0);
    chk("rst_draw_entry", 32'(bus.draw_entry), 0);
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    m_count = 0;
    m_pend  = 1'b0;
    chk("clr_count", 32'(bus.count), 0);
    chk("clr_playing", 32'(bus.playing), 0);
    chk("clr_draw_req", 32'(bus.draw_req), 0);
  endtask

  task automatic record(input logic [3:0] n, input logic [1:0] o);
    logic accept;
    int   got;
    accept = (m_count < DEPTH) && !m_pend;
    bus.note_data   = n;
    bus.octave_data = o;
    bus.ld_note     = 1'b1;
    if (accept) begin
      dq.push_back((m_count << 8) | int'({o, n}));
      m_mem[m_count] = {o, n};
      m_count++;
      m_pend = 1'b1;
    end
    cyc();
    bus.ld_note = 1'b0;
    chk("rec_count", 32'(bus.count), 32'(m_count));
    chk("rec_full", 32'(bus.full), 32'(m_count == DEPTH));
    chk("rec_draw_req", 32'(bus.draw_req), 32'(m_pend));
    if (bus.draw_req && dq.size() > 0) begin
      got = dq.pop_front();
      chk("draw_slot", 32'(bus.draw_slot), 32'(got >> 8));
      chk("draw_entry", 32'(bus.draw_entry), 32'(got & 8'hff));
    end
  endtask

  task automatic ack();
    bus.draw_ack = 1'b1;
    cyc();
    bus.draw_ack = 1'b0;
    m_pend = 1'b0;
    chk("ack_draw_req", 32'(bus.draw_req), 0);
  endtask

  task automatic push_play(input logic lp, input int ncyc);
    play_t p;
    int    slot;
    for (int k = 0; k < ncyc; k++) begin
      if (lp || k < m_count * TICKS) begin
        slot = (k / TICKS) % m_count;
        p.v = 1'b1;
        p.e = m_mem[slot];
        p.d = lp && (k > 0) && (k % TICKS == 0) && (slot == 0);
      end else begin
        p.v = 1'b0;
        p.e = '0;
        p.d = (k == m_count * TICKS);
      end
      pq.push_back(p);
    end
  endtask

  task automatic drain();
    play_t p;
    while (pq.size() > 0) begin
      p = pq.pop_front();
      chk("pb_valid", 32'(bus.note_valid), 32'(p.v));
      chk("pb_playing", 32'(bus.playing), 32'(p.v));
      chk("pb_note", 32'({bus.cur_octave, bus.cur_note}), 32'(p.e));
      chk("pb_done", 32'(bus.done), 32'(p.d));
      cyc();
    end
  endtask

  initial begin
    reset           = 1'b0;
    bus.note_data   = '0;
    bus.octave_data = '0;
    bus.ld_note     = 1'b0;
    bus.play        = 1'b0;
    bus.stop        = 1'b0;
    bus.clear       = 1'b0;
    bus.loop_mode   = 1'b0;
    bus.draw_ack    = 1'b0;
    m_count         = 0;
    m_pend          = 1'b0;
    cyc();
    cyc();
    chk_reset_vals();
    reset = 1'b1;
    cyc();

    // Record two entries with handshakes.
    record(4'h5, 2'd2);
    ack();
    record(4'h9, 2'd1);
    ack();
    chk("two_count", 32'(bus.count), 2);

    // One-shot playback of two slots.
    bus.loop_mode = 1'b0;
    bus.play = 1'b1;
    push_play(1'b0, 2 * TICKS + 2);
    cyc();
    bus.play = 1'b0;
    drain();

    // Looping playback of three slots, then stop.
    record(4'h3, 2'd2);
    ack();
    bus.loop_mode = 1'b1;
    bus.play = 1'b1;
    push_play(1'b1, 3 * TICKS + 4);
    cyc();
    bus.play = 1'b0;
    drain();
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    bus.loop_mode = 1'b0;
    chk("stop_playing", 32'(bus.playing), 0);
    chk("stop_valid", 32'(bus.note_valid), 0);
    chk("stop_done", 32'(bus.done), 0);
    chk("stop_cur", 32'({bus.cur_octave, bus.cur_note}), 0);
    chk("stop_count", 32'(bus.count), 3);

    // Fill to DEPTH, then overflow and unacked writes are dropped.
    do_clear();
    for (int i = 0; i < DEPTH; i++) begin
      record(4'(i + 7), 2'(i));
      ack();
    end
    record(4'hf, 2'd3);
    do_clear();
    record(4'h1, 2'd1);
    record(4'h2, 2'd2);
    ack();

    // play and ld_note together: play wins.
    bus.play        = 1'b1;
    bus.ld_note     = 1'b1;
    bus.note_data   = 4'hc;
    bus.octave_data = 2'd3;
    push_play(1'b0, TICKS + 2);
    cyc();
    bus.play    = 1'b0;
    bus.ld_note = 1'b0;
    chk("pl_ld_count", 32'(bus.count), 1);
    chk("pl_ld_draw", 32'(bus.draw_req), 0);
    drain();

    // play with no slots stays idle.
    do_clear();
    bus.play = 1'b1;
    cyc();
    bus.play = 1'b0;
    chk("empty_play", 32'(bus.playing), 0);
    chk("empty_valid", 32'(bus.note_valid), 0);

    // clear in the middle of playback.
    record(4'h4, 2'd0);
    ack();
    record(4'h8, 2'd3);
    ack();
    bus.play = 1'b1;
    cyc();
    bus.play = 1'b0;
    cyc();
    cyc();
    cyc();
    chk("mid_playing", 32'(bus.playing), 1);
    chk("mid_note", 32'({bus.cur_octave, bus.cur_note}), 32'(m_mem[1]));
    do_clear();
    chk("clr_valid", 32'(bus.note_valid), 0);
    chk("clr_full", 32'(bus.full), 0);

    // Reset during playback with a draw request pending.
    record(4'h6, 2'd1);
    bus.play = 1'b1;
    cyc();
    bus.play = 1'b0;
    cyc();
    chk("pre_rst_playing", 32'(bus.playing), 1);
    chk("pre_rst_draw", 32'(bus.draw_req), 1);
    chk("pre_rst_slot", 32'(bus.draw_slot), 0);
    reset = 1'b0;
    bus.ld_note = 1'b1;
    cyc();
    bus.ld_note = 1'b0;
    chk_reset_vals();
    reset = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of note slots; legal values are 2..256.
REQ-002 The block SHALL have parameter TICKS, default 12500000, meaning the clk cycles per played note; legal values are 1 and above.
REQ-003 The block SHALL have parameter AW, default 4, meaning the slot index width, equal to ceil(log2(DEPTH)).
REQ-004 Ports SHALL be as follows, one per line (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-low
- note_data  in  4  note code to record
- octave_data  in  2  octave to record
- ld_note  in  1  one-cycle record strobe
- play  in  1  one-cycle start-playback strobe
- stop  in  1  one-cycle abort-playback strobe
- clear  in  1  one-cycle erase-all strobe
- loop_mode  in  1  when high, playback repeats
- draw_ack  in  1  draw request consumed
- cur_note  out  4  note being played
- cur_octave  out  2  octave being played
- note_valid  out  1  cur_note/cur_octave meaningful
- playing  out  1  state is PLAY
- done  out  1  one-cycle end-of-sequence pulse
- count  out  AW+1  number of stored slots
- full  out  1  count == DEPTH
- draw_req  out  1  new slot awaiting display
- draw_slot  out  AW  slot index to draw
- draw_entry  out  6  {octave,note} to draw

Function
REQ-005 Storage SHALL be an internal DEPTH x 6-bit register array, each entry holding {octave_data, note_data}; no external memory SHALL be used.
REQ-006 The state machine SHALL have two states, IDLE and PLAY, with all outputs registered.
REQ-007 Strobe priority on any edge SHALL be clear > stop > play > ld_note; lower-priority strobes in that cycle SHALL be ignored.
REQ-008 In IDLE, ld_note with !full and !draw_req SHALL write the entry at slot count, increment count, and on the same edge set draw_req=1, draw_slot=old count, draw_entry=written value.
REQ-009 ld_note SHALL be dropped with no state change when full, when draw_req=1, or when in PLAY.
REQ-010 draw_req SHALL stay high with draw_slot and draw_entry stable until a cycle with draw_ack=1, then clear on that edge; draw_ack while draw_req=0 SHALL be ignored.
REQ-011 In IDLE, play with count>0 SHALL enter PLAY on that edge with rd_ptr=0, tick counter=0, note_valid=1, and cur_* = slot 0; play with count==0 SHALL be ignored.
REQ-012 In PLAY, the tick counter SHALL count 0..TICKS-1; on the edge where it equals TICKS-1, it SHALL reset to 0 and the sequencer SHALL advance.
REQ-013 On advance with rd_ptr < count-1: rd_ptr SHALL increment and cur_* SHALL load the next slot.
REQ-014 On advance with rd_ptr == count-1 and loop_mode=1: rd_ptr SHALL wrap to 0, cur_* SHALL load slot 0, and done SHALL pulse for 1 cycle.
REQ-015 On advance with rd_ptr == count-1 and loop_mode=0: the state SHALL go to IDLE, note_valid SHALL go to 0, and done SHALL pulse for 1 cycle.
REQ-016 loop_mode SHALL be sampled only at the advance edge.
REQ-017 stop in PLAY SHALL go to IDLE, set note_valid=0, and leave done=0; stop in IDLE SHALL be ignored.
REQ-018 clear in any state SHALL set count=0, go to IDLE, set note_valid=0, draw_req=0, done=0, and rd_ptr=0; array contents need not be erased.
REQ-019 When note_valid=0, cur_note and cur_octave SHALL be 0.
REQ-020 full SHALL equal (count==DEPTH) and SHALL be registered consistently with count.
REQ-021 playing SHALL be 1 exactly when state is PLAY.

Reset
REQ-022 While reset=0 at an edge, the block SHALL enter IDLE with count=0, rd_ptr=0, tick=0, and cur_note=0, cur_octave=0, note_valid=0, playing=0, done=0, full=0, draw_req=0, draw_slot=0, draw_entry=0.
REQ-023 Reset SHALL override all strobes, including mid-PLAY and with draw_req pending.

Verification (DEPTH=4, TICKS=3)
REQ-024 Record: ld_note with {2,5}, ack, then {1,9}, ack -> count=2, draw_slot 0 then 1, draw_entry 0x25 then 0x19.
REQ-025 Full/handshake: 4 acked writes then ld_note -> full=1, count=4, no draw_req; a second ld_note before ack -> dropped, count unchanged.
REQ-026 Playback, loop=0, 2 slots: play -> slot 0 for 3 cycles, slot 1 for 3 cycles, then done=1 for 1 cycle, note_valid=0, playing=0.
REQ-027 Loop: loop=1, 3 slots -> sequence 0,1,2,0 with done pulsing at each wrap; stop -> IDLE next edge, done=0.
REQ-028 Simultaneous/edge cases: play+ld_note same cycle -> play wins, count unchanged; play with count=0 -> stays IDLE; clear mid-PLAY -> count=0, IDLE.
REQ-029 Reset mid-PLAY with draw_req=1 -> all outputs at REQ-022 values on the next edge.
